// File: rtl/cache_maint_pkg.sv
// Shared types and helpers for the cache maintenance arbiter.
package cache_maint_pkg;

  typedef enum logic {
    OP_RELOAD  = 1'b0,
    OP_REFRESH = 1'b1
  } maint_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } maint_state_e;

  // Clears the line-offset bits; callers zero-extend to 64 bits and truncate the result.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned line_bits);
    logic [63:0] r;
    r = addr;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < line_bits) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_maint_pick.sv
// Combinational winner selector for the maintenance arbiter.
// CACHE_MAINT_RR_EN selects round-robin from ptr_i; otherwise lowest index wins.
module cache_maint_pick
  import cache_maint_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

`ifdef CACHE_MAINT_RR_EN
  always_comb begin
    int unsigned j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (32'(ptr_i) + k) % N_REQ;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any_o && valid_i[i]) begin
        any_o      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/cache_maint_arbiter.sv
// Shares one cache refresh/reload engine between N_REQ maintenance requesters.
// Define CACHE_MAINT_RR_EN for round-robin selection (fixed priority otherwise).
module cache_maint_arbiter
  import cache_maint_pkg::*;
#(
  parameter int unsigned N_REQ               = 2,
  parameter int unsigned CACHE_PADDR_SIZE    = 32,
  parameter int unsigned CACHE_LINEADDR_SIZE = 7
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic [N_REQ-1:0]                  req_valid_i,
  input  logic [N_REQ-1:0]                  req_op_i,
  input  logic [N_REQ*CACHE_PADDR_SIZE-1:0] req_addr_i,
  input  logic [N_REQ-1:0]                  req_nocheck_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  output logic [N_REQ-1:0]                  req_done_o,
  output logic [N_REQ-1:0]                  req_fault_o,
  output logic                              busy_o,
  output logic                              eng_refersh_req_o,
  output logic                              eng_reload_req_o,
  output logic [CACHE_PADDR_SIZE-1:0]       eng_reload_addr_o,
  output logic                              eng_nocheck_dirty_o,
  input  logic                              eng_refersh_done_i,
  input  logic                              eng_reload_done_i,
  input  logic                              eng_refersh_fault_i,
  input  logic                              eng_reload_fault_i
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  maint_state_e          state_q;
  maint_op_e             op_q;
  logic [IDX_W-1:0]      owner_q;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      pick_idx;
  logic [N_REQ-1:0]      pick_grant;
  logic                  pick_any;
  logic                  accept;
  logic                  done_hit;
  logic                  fault_hit;
  logic [63:0]           addr_ext;
  logic [CACHE_PADDR_SIZE-1:0] aligned_addr;

  cache_maint_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign accept = (state_q == IDLE) && pick_any;

  always_comb begin
    addr_ext = '0;
    addr_ext[CACHE_PADDR_SIZE-1:0] =
      req_addr_i[pick_idx*CACHE_PADDR_SIZE +: CACHE_PADDR_SIZE];
    aligned_addr = CACHE_PADDR_SIZE'(line_align(addr_ext, CACHE_LINEADDR_SIZE));
  end

  // Status for the op that was not issued never completes the command.
  always_comb begin
    done_hit  = 1'b0;
    fault_hit = 1'b0;
    if (state_q == BUSY) begin
      if (op_q == OP_RELOAD) begin
        done_hit  = eng_reload_done_i;
        fault_hit = eng_reload_fault_i;
      end else begin
        done_hit  = eng_refersh_done_i;
        fault_hit = eng_refersh_fault_i;
      end
    end
  end

  // Ready is masked during reset so nothing looks accepted while the FSM is held.
  always_comb begin
    req_ready_o = '0;
    req_done_o  = '0;
    req_fault_o = '0;
    if (state_q == IDLE && !arst_i) req_ready_o = pick_grant;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        req_fault_o[i] = fault_hit;
        req_done_o[i]  = done_hit && !fault_hit;
      end
    end
  end

  assign busy_o = (state_q == BUSY);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q             <= IDLE;
      op_q                <= OP_RELOAD;
      owner_q             <= '0;
      eng_refersh_req_o   <= 1'b0;
      eng_reload_req_o    <= 1'b0;
      eng_reload_addr_o   <= '0;
      eng_nocheck_dirty_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q             <= BUSY;
            op_q                <= maint_op_e'(req_op_i[pick_idx]);
            owner_q             <= pick_idx;
            eng_reload_addr_o   <= aligned_addr;
            eng_nocheck_dirty_o <= req_nocheck_i[pick_idx];
            eng_refersh_req_o   <= req_op_i[pick_idx];
            eng_reload_req_o    <= !req_op_i[pick_idx];
          end
        end
        BUSY: begin
          if (done_hit || fault_hit) begin
            state_q           <= IDLE;
            eng_refersh_req_o <= 1'b0;
            eng_reload_req_o  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CACHE_MAINT_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_cache_maint_arbiter.sv
// Self-checking bench for cache_maint_arbiter: directed scenarios plus randomized traffic.
module tb_cache_maint_arbiter;

  localparam int N = 2;
  localparam int P = 32;
  localparam int L = 7;

  logic           clk_i = 1'b0;
  logic           arst_i;
  logic [N-1:0]   req_valid_i, req_op_i, req_nocheck_i;
  logic [N*P-1:0] req_addr_i;
  logic [N-1:0]   req_ready_o, req_done_o, req_fault_o;
  logic           busy_o, eng_refersh_req_o, eng_reload_req_o, eng_nocheck_dirty_o;
  logic [P-1:0]   eng_reload_addr_o;
  logic           eng_refersh_done_i, eng_reload_done_i, eng_refersh_fault_i, eng_reload_fault_i;

  cache_maint_arbiter #(
    .N_REQ               (N),
    .CACHE_PADDR_SIZE    (P),
    .CACHE_LINEADDR_SIZE (L)
  ) dut (
    .clk_i               (clk_i),
    .arst_i              (arst_i),
    .req_valid_i         (req_valid_i),
    .req_op_i            (req_op_i),
    .req_addr_i          (req_addr_i),
    .req_nocheck_i       (req_nocheck_i),
    .req_ready_o         (req_ready_o),
    .req_done_o          (req_done_o),
    .req_fault_o         (req_fault_o),
    .busy_o              (busy_o),
    .eng_refersh_req_o   (eng_refersh_req_o),
    .eng_reload_req_o    (eng_reload_req_o),
    .eng_reload_addr_o   (eng_reload_addr_o),
    .eng_nocheck_dirty_o (eng_nocheck_dirty_o),
    .eng_refersh_done_i  (eng_refersh_done_i),
    .eng_reload_done_i   (eng_reload_done_i),
    .eng_refersh_fault_i (eng_refersh_fault_i),
    .eng_reload_fault_i  (eng_reload_fault_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what is outstanding, for whom, and the arbitration pointer.
  bit           m_busy;
  int           m_owner;
  bit           m_op;
  logic [P-1:0] m_addr;
  bit           m_nocheck;
  int           m_ptr;

  function automatic int model_pick(input logic [N-1:0] v);
`ifdef CACHE_MAINT_RR_EN
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
    for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [P-1:0] model_align(input logic [P-1:0] a);
    return (a >> L) << L;
  endfunction

  task automatic idle_inputs();
    req_valid_i = '0; req_op_i = '0; req_nocheck_i = '0; req_addr_i = '0;
    eng_refersh_done_i = 0; eng_reload_done_i = 0;
    eng_refersh_fault_i = 0; eng_reload_fault_i = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_op = 0; m_addr = '0; m_nocheck = 0; m_ptr = 0;
  endtask

  // Advance the model with the inputs present this cycle, then move to the next falling edge.
  task automatic tick();
    int w;
    if (!m_busy) begin
      w = model_pick(req_valid_i);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_op = req_op_i[w];
        m_addr = model_align(req_addr_i[w*P +: P]);
        m_nocheck = req_nocheck_i[w];
        m_ptr = (w + 1) % N;
      end
    end else if (m_op ? (eng_refersh_done_i || eng_refersh_fault_i)
                      : (eng_reload_done_i || eng_reload_fault_i)) begin
      m_busy = 0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    idle_inputs();
    arst_i = 1;
    req_valid_i = 2'b11;
    model_reset();
    @(negedge clk_i); @(negedge clk_i);
    #2;
    n_cmp++; if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", req_ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if ({eng_refersh_req_o, eng_reload_req_o, eng_nocheck_dirty_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_eng_cmd got %b want 000", {eng_refersh_req_o, eng_reload_req_o, eng_nocheck_dirty_o}); end
    n_cmp++; if (eng_reload_addr_o !== '0) begin n_err++; $display("FAIL reset_addr got %h want 0", eng_reload_addr_o); end
    n_cmp++; if ({req_done_o, req_fault_o} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses got %b want 0000", {req_done_o, req_fault_o}); end
    req_valid_i = '0;
    @(negedge clk_i);
    arst_i = 0;
  endtask

  task automatic test_reload_basic();
    req_valid_i = 2'b01; req_op_i = 2'b00; req_addr_i[0 +: P] = 32'h8000_1234;
    #2;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL basic_ready got %b want 01", req_ready_o); end
    tick();
    req_valid_i = '0;
    #2;
    n_cmp++; if (eng_reload_req_o !== 1'b1 || eng_refersh_req_o !== 1'b0) begin
      n_err++; $display("FAIL basic_cmd got reload=%b refresh=%b want 1/0", eng_reload_req_o, eng_refersh_req_o); end
    n_cmp++; if (eng_reload_addr_o !== 32'h8000_1200) begin n_err++; $display("FAIL basic_addr got %h want 80001200", eng_reload_addr_o); end
    n_cmp++; if (req_ready_o !== 2'b00 || busy_o !== 1'b1) begin
      n_err++; $display("FAIL basic_busy got ready=%b busy=%b want 00/1", req_ready_o, busy_o); end
    for (int i = 0; i < 19; i++) tick();
    n_cmp++; if (busy_o !== 1'b1 || req_done_o !== 2'b00) begin
      n_err++; $display("FAIL basic_wait got busy=%b done=%b want 1/00", busy_o, req_done_o); end
    eng_reload_done_i = 1;
    #2;
    n_cmp++; if (req_done_o !== 2'b01 || req_fault_o !== 2'b00) begin
      n_err++; $display("FAIL basic_done got done=%b fault=%b want 01/00", req_done_o, req_fault_o); end
    tick();
    eng_reload_done_i = 0;
    #2;
    n_cmp++; if (eng_reload_req_o !== 1'b0 || busy_o !== 1'b0 || req_done_o !== 2'b00) begin
      n_err++; $display("FAIL basic_after got req=%b busy=%b done=%b want 0/0/00", eng_reload_req_o, busy_o, req_done_o); end
  endtask

  task automatic test_priority();
    int w, o;
    logic [P-1:0] a0, a1;
    a0 = $urandom; a1 = $urandom;
    req_valid_i = 2'b11; req_op_i = 2'b00; req_addr_i = {a1, a0};
    w = model_pick(2'b11);
    o = 1 - w;
`ifndef CACHE_MAINT_RR_EN
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL prio_model got %0d want 0", w); end
`endif
    #2;
    n_cmp++; if (req_ready_o !== 2'(1 << w)) begin n_err++; $display("FAIL prio_first got %b want %b", req_ready_o, 2'(1 << w)); end
    tick();
    req_valid_i = 2'(1 << o);
    #2;
    n_cmp++; if (eng_reload_addr_o !== model_align(w ? a1 : a0) || req_ready_o !== 2'b00) begin
      n_err++; $display("FAIL prio_first_addr got %h ready=%b want %h/00", eng_reload_addr_o, req_ready_o, model_align(w ? a1 : a0)); end
    for (int i = 0; i < 3; i++) tick();
    eng_reload_done_i = 1;
    #2;
    n_cmp++; if (req_done_o !== 2'(1 << w) || req_ready_o !== 2'b00) begin
      n_err++; $display("FAIL prio_done_cycle got done=%b ready=%b want %b/00", req_done_o, req_ready_o, 2'(1 << w)); end
    tick();
    eng_reload_done_i = 0;
    #2;
    n_cmp++; if (req_ready_o !== 2'(1 << o) || eng_reload_req_o !== 1'b0) begin
      n_err++; $display("FAIL prio_second_accept got ready=%b req=%b want %b/0", req_ready_o, eng_reload_req_o, 2'(1 << o)); end
    tick();
    req_valid_i = '0;
    #2;
    n_cmp++; if (eng_reload_req_o !== 1'b1 || eng_reload_addr_o !== model_align(o ? a1 : a0)) begin
      n_err++; $display("FAIL prio_second_cmd got req=%b addr=%h want 1/%h", eng_reload_req_o, eng_reload_addr_o, model_align(o ? a1 : a0)); end
    eng_reload_done_i = 1;
    #2;
    n_cmp++; if (req_done_o !== 2'(1 << o)) begin n_err++; $display("FAIL prio_second_done got %b want %b", req_done_o, 2'(1 << o)); end
    tick();
    idle_inputs();
  endtask

  task automatic test_refresh_nocheck();
    req_valid_i = 2'b10; req_op_i = 2'b10; req_nocheck_i = 2'b10; req_addr_i = {32'h1234_5678, 32'h0};
    #2;
    n_cmp++; if (req_ready_o !== 2'b10) begin n_err++; $display("FAIL refr_ready got %b want 10", req_ready_o); end
    tick();
    idle_inputs();
    #2;
    n_cmp++; if ({eng_refersh_req_o, eng_reload_req_o, eng_nocheck_dirty_o} !== 3'b101) begin
      n_err++; $display("FAIL refr_cmd got %b want 101", {eng_refersh_req_o, eng_reload_req_o, eng_nocheck_dirty_o}); end
    eng_reload_done_i = 1;
    #2;
    n_cmp++; if (req_done_o !== 2'b00) begin n_err++; $display("FAIL refr_wrong_done got %b want 00", req_done_o); end
    tick();
    eng_reload_done_i = 0;
    #2;
    n_cmp++; if (busy_o !== 1'b1 || eng_reload_req_o !== 1'b0 || eng_refersh_req_o !== 1'b1) begin
      n_err++; $display("FAIL refr_still_busy got busy=%b rl=%b rf=%b want 1/0/1", busy_o, eng_reload_req_o, eng_refersh_req_o); end
    eng_refersh_done_i = 1;
    #2;
    n_cmp++; if (req_done_o !== 2'b10) begin n_err++; $display("FAIL refr_done got %b want 10", req_done_o); end
    tick();
    eng_refersh_done_i = 0;
    #2;
    n_cmp++; if (eng_refersh_req_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL refr_after got req=%b busy=%b want 0/0", eng_refersh_req_o, busy_o); end
  endtask

  task automatic test_fault();
    req_valid_i = 2'b01; req_op_i = 2'b00; req_addr_i = {32'h0, 32'hCAFE_F0F0};
    tick();
    idle_inputs();
    tick(); tick();
    eng_reload_fault_i = 1;
    #2;
    n_cmp++; if (req_fault_o !== 2'b01 || req_done_o !== 2'b00) begin
      n_err++; $display("FAIL fault_pulse got fault=%b done=%b want 01/00", req_fault_o, req_done_o); end
    tick();
    eng_reload_fault_i = 0;
    #2;
    n_cmp++; if (busy_o !== 1'b0 || req_fault_o !== 2'b00 || eng_reload_req_o !== 1'b0) begin
      n_err++; $display("FAIL fault_after got busy=%b fault=%b req=%b want 0/00/0", busy_o, req_fault_o, eng_reload_req_o); end
  endtask

  task automatic test_spurious();
    req_valid_i = 2'b10; req_op_i = 2'b00; req_addr_i = {32'hFFFF_FFFF, 32'h0};
    tick();
    idle_inputs();
    eng_refersh_done_i = 1; eng_refersh_fault_i = 1;
    #2;
    n_cmp++; if (req_done_o !== 2'b00 || req_fault_o !== 2'b00) begin
      n_err++; $display("FAIL spur_pulse got done=%b fault=%b want 00/00", req_done_o, req_fault_o); end
    tick();
    idle_inputs();
    #2;
    n_cmp++; if (busy_o !== 1'b1 || eng_reload_addr_o !== 32'hFFFF_FF80) begin
      n_err++; $display("FAIL spur_busy got busy=%b addr=%h want 1/ffffff80", busy_o, eng_reload_addr_o); end
    eng_reload_done_i = 1;
    #2;
    n_cmp++; if (req_done_o !== 2'b10) begin n_err++; $display("FAIL spur_done got %b want 10", req_done_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    req_valid_i = 2'b01; req_op_i = 2'b00; req_addr_i = {32'h0, 32'h4000_0080};
    tick();
    idle_inputs();
    #1;
    arst_i = 1; eng_reload_done_i = 1;
    #1;
    n_cmp++; if ({busy_o, eng_reload_req_o, eng_refersh_req_o, eng_nocheck_dirty_o} !== 4'b0000 || eng_reload_addr_o !== '0) begin
      n_err++; $display("FAIL rstmid_outputs got %b addr=%h want 0000/0", {busy_o, eng_reload_req_o, eng_refersh_req_o, eng_nocheck_dirty_o}, eng_reload_addr_o); end
    n_cmp++; if (req_done_o !== 2'b00 || req_fault_o !== 2'b00) begin
      n_err++; $display("FAIL rstmid_pulse got done=%b fault=%b want 00/00", req_done_o, req_fault_o); end
    @(posedge clk_i); @(negedge clk_i);
    arst_i = 0; eng_reload_done_i = 0;
    model_reset();
    req_valid_i = 2'b01; req_addr_i = {32'h0, 32'h0000_1FFF};
    #2;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL rstmid_accept got %b want 01", req_ready_o); end
    tick();
    idle_inputs();
    #2;
    n_cmp++; if (eng_reload_req_o !== 1'b1 || eng_reload_addr_o !== 32'h0000_1F80) begin
      n_err++; $display("FAIL rstmid_cmd got req=%b addr=%h want 1/00001f80", eng_reload_req_o, eng_reload_addr_o); end
    eng_reload_done_i = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    int w, ev;
    logic [N-1:0] exp_ready, exp_done, exp_fault;
    for (int c = 0; c < 400; c++) begin
      req_valid_i = N'($urandom_range(0, 3));
      req_op_i = N'($urandom);
      req_nocheck_i = N'($urandom);
      req_addr_i = {$urandom, $urandom};
      ev = $urandom_range(0, 7);
      eng_reload_done_i = (ev == 0); eng_reload_fault_i = (ev == 1);
      eng_refersh_done_i = (ev == 2); eng_refersh_fault_i = (ev == 3);
      #2;
      w = model_pick(req_valid_i);
      exp_ready = (!m_busy && w >= 0) ? N'(1 << w) : '0;
      exp_done  = (m_busy && (m_op ? eng_refersh_done_i : eng_reload_done_i)) ? N'(1 << m_owner) : '0;
      exp_fault = (m_busy && (m_op ? eng_refersh_fault_i : eng_reload_fault_i)) ? N'(1 << m_owner) : '0;
      n_cmp++; if (req_ready_o !== exp_ready) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, req_ready_o, exp_ready); end
      n_cmp++; if (req_done_o !== exp_done) begin n_err++; $display("FAIL rnd_done cyc %0d got %b want %b", c, req_done_o, exp_done); end
      n_cmp++; if (req_fault_o !== exp_fault) begin n_err++; $display("FAIL rnd_fault cyc %0d got %b want %b", c, req_fault_o, exp_fault); end
      n_cmp++; if ({busy_o, eng_reload_req_o, eng_refersh_req_o} !== {m_busy, m_busy && !m_op, m_busy && m_op}) begin
        n_err++; $display("FAIL rnd_cmd cyc %0d got %b want %b", c, {busy_o, eng_reload_req_o, eng_refersh_req_o}, {m_busy, m_busy && !m_op, m_busy && m_op}); end
      if (m_busy) begin
        n_cmp++; if (eng_reload_addr_o !== m_addr || eng_nocheck_dirty_o !== m_nocheck) begin
          n_err++; $display("FAIL rnd_fields cyc %0d got %h/%b want %h/%b", c, eng_reload_addr_o, eng_nocheck_dirty_o, m_addr, m_nocheck); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reload_basic();
    test_priority();
    test_refresh_nocheck();
    test_fault();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
